// File: rtl/inst_fetch_ctrl_if.sv
// Instruction-side SRAM-like bus: one request/accept handshake plus a data return strobe.
// The fetch sequencer is the master; the instruction memory (or its model) is the slave.
interface inst_fetch_ctrl_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  modport master (
    output inst_req,
    output inst_addr,
    input  inst_addr_ok,
    input  inst_data_ok,
    input  inst_rdata
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_addr_ok,
    output inst_data_ok,
    output inst_rdata
  );
endinterface

// File: rtl/inst_fetch_ctrl.sv
// IF-stage fetch sequencer: owns the fetch PC, merges eret/exception/branch redirects,
// keeps one bus transaction in flight and buffers one instruction toward decode.
module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_ADDR = 32'hbfc0_0000,
  parameter logic [31:0] EXC_ADDR   = 32'hbfc0_0380
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     stall,
  input  logic                     br_take,
  input  logic [31:0]              br_target,
  input  logic                     exc_oc,
  input  logic                     eret,
  input  logic [31:0]              epc,
  inst_fetch_ctrl_if.master        bus,
  output logic                     if_valid,
  output logic [31:0]              if_pc,
  output logic [31:0]              if_inst
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] fetch_pc;
  logic [31:0] pend_pc;
  logic        cancel;
  logic        redir;
  logic [31:0] redir_target;

  // eret outranks exception, exception outranks branch
  always_comb begin
    redir        = eret | exc_oc | br_take;
    redir_target = br_target;
    if (eret) begin
      redir_target = epc;
    end else if (exc_oc) begin
      redir_target = EXC_ADDR;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        if (bus.inst_addr_ok) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (bus.inst_data_ok) begin
          state_nxt = (redir || cancel) ? REQ : HOLD;
        end
      end
      HOLD: begin
        if (redir || !stall) begin
          state_nxt = REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.inst_req  = (state == REQ);
    bus.inst_addr = fetch_pc;
  end

  // A redirect that arrives while a fetch is in flight is parked in pend_pc;
  // the address is only retargeted once the stale data has drained.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      fetch_pc <= RESET_ADDR;
      pend_pc  <= '0;
      cancel   <= 1'b0;
      if_valid <= 1'b0;
      if_pc    <= '0;
      if_inst  <= '0;
    end else begin
      case (state)
        IDLE: begin
          fetch_pc <= redir ? redir_target : RESET_ADDR;
        end
        REQ: begin
          if (redir) begin
            cancel  <= 1'b1;
            pend_pc <= redir_target;
          end
        end
        WAIT: begin
          if (bus.inst_data_ok) begin
            if (redir) begin
              fetch_pc <= redir_target;
              cancel   <= 1'b0;
            end else if (cancel) begin
              fetch_pc <= pend_pc;
              cancel   <= 1'b0;
            end else begin
              if_inst  <= bus.inst_rdata;
              if_pc    <= fetch_pc;
              if_valid <= 1'b1;
            end
          end else if (redir) begin
            cancel  <= 1'b1;
            pend_pc <= redir_target;
          end
        end
        HOLD: begin
          if (redir) begin
            if_valid <= 1'b0;
            fetch_pc <= redir_target;
          end else if (!stall) begin
            if_valid <= 1'b0;
            fetch_pc <= fetch_pc + 32'd4;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: directed scenarios with a zero-wait bus, then a randomized
// bus/redirect/stall run checked against a transaction-level model of the fetch stream.
module tb_inst_fetch_ctrl;

  localparam logic [31:0] RESET_ADDR = 32'hbfc0_0000;
  localparam logic [31:0] EXC_ADDR   = 32'hbfc0_0380;

  logic        clk = 1'b0;
  logic        resetn;
  logic        stall;
  logic        br_take;
  logic [31:0] br_target;
  logic        exc_oc;
  logic        eret;
  logic [31:0] epc;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  int checks = 0;
  int errors = 0;

  inst_fetch_ctrl_if bus();

  inst_fetch_ctrl dut (
    .clk       (clk),
    .resetn    (resetn),
    .stall     (stall),
    .br_take   (br_take),
    .br_target (br_target),
    .exc_oc    (exc_oc),
    .eret      (eret),
    .epc       (epc),
    .bus       (bus),
    .if_valid  (if_valid),
    .if_pc     (if_pc),
    .if_inst   (if_inst)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic br, input logic [31:0] bt,
                               input logic ex, input logic er, input logic [31:0] ep);
    stall     = st;
    br_take   = br;
    br_target = bt;
    exc_oc    = ex;
    eret      = er;
    epc       = ep;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5a5a_c3c3;
  endfunction

  function automatic logic [31:0] randTarget();
    logic [31:0] t;
    t = $urandom;
    if ($urandom_range(0, 7) == 0) begin
      t = 32'hffff_fffc;
    end
    return t & 32'hffff_fffc;
  endfunction

  // Starts in REQ at a negedge; zero-wait bus returns the address as data; ends in HOLD.
  task automatic fetchZeroWait(input logic [31:0] a);
    checkOutput("zw_req", 32'(bus.inst_req), 32'd1);
    checkOutput("zw_addr", bus.inst_addr, a);
    bus.inst_addr_ok = 1'b1;
    tick();
    bus.inst_addr_ok = 1'b0;
    checkOutput("zw_wait_req", 32'(bus.inst_req), 32'd0);
    checkOutput("zw_wait_valid", 32'(if_valid), 32'd0);
    bus.inst_data_ok = 1'b1;
    bus.inst_rdata   = a;
    tick();
    bus.inst_data_ok = 1'b0;
    checkOutput("zw_valid", 32'(if_valid), 32'd1);
    checkOutput("zw_pc", if_pc, a);
    checkOutput("zw_inst", if_inst, a);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_req"}, 32'(bus.inst_req), 32'd0);
    checkOutput({tag, "_addr"}, bus.inst_addr, RESET_ADDR);
    checkOutput({tag, "_valid"}, 32'(if_valid), 32'd0);
    checkOutput({tag, "_pc"}, if_pc, 32'd0);
    checkOutput({tag, "_inst"}, if_inst, 32'd0);
  endtask

  logic [31:0] exp_pc, out_addr, prev_addr;
  logic        model_valid, dirty, outstanding, stale_pending, deliver, redir;
  logic        prev_req, prev_aok, prev_rstn, first;
  int          lat, since_deliv;

  initial begin
    resetn = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b0;
    bus.inst_rdata   = '0;
    repeat (2) @(negedge clk);
    checkResetState("reset");

    // IDLE for one cycle, then the first request at RESET_ADDR
    resetn = 1'b1;
    checkOutput("idle_req", 32'(bus.inst_req), 32'd0);
    tick();
    fetchZeroWait(RESET_ADDR);

    stall = 1'b1;
    repeat (5) begin
      tick();
      checkOutput("stall_valid", 32'(if_valid), 32'd1);
      checkOutput("stall_pc", if_pc, RESET_ADDR);
      checkOutput("stall_inst", if_inst, RESET_ADDR);
      checkOutput("stall_req", 32'(bus.inst_req), 32'd0);
    end
    stall = 1'b0;
    tick();
    checkOutput("consume_valid", 32'(if_valid), 32'd0);

    // branch while waiting for bfc00004: the returned word is dropped
    checkOutput("br_req_addr", bus.inst_addr, 32'hbfc0_0004);
    bus.inst_addr_ok = 1'b1;
    tick();
    bus.inst_addr_ok = 1'b0;
    applyStimulus(1'b0, 1'b1, 32'hbfc0_0100, 1'b0, 1'b0, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    repeat (2) begin
      tick();
      checkOutput("br_wait_req", 32'(bus.inst_req), 32'd0);
    end
    bus.inst_data_ok = 1'b1;
    bus.inst_rdata   = 32'hbfc0_0004;
    tick();
    bus.inst_data_ok = 1'b0;
    checkOutput("br_drop_valid", 32'(if_valid), 32'd0);
    fetchZeroWait(32'hbfc0_0100);
    tick();
    fetchZeroWait(32'hbfc0_0104);

    // all three redirect sources at once: eret wins
    applyStimulus(1'b0, 1'b1, 32'h0000_4000, 1'b1, 1'b1, 32'h8000_1000);
    tick();
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    checkOutput("prio_eret_valid", 32'(if_valid), 32'd0);
    fetchZeroWait(32'h8000_1000);
    applyStimulus(1'b0, 1'b1, 32'h0000_4000, 1'b1, 1'b0, 32'h8000_1000);
    tick();
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    checkOutput("prio_exc_req", 32'(bus.inst_req), 32'd1);
    checkOutput("prio_exc_addr", bus.inst_addr, EXC_ADDR);

    // branch during an unaccepted request: address holds, data is dropped
    applyStimulus(1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    repeat (3) begin
      checkOutput("hold_req", 32'(bus.inst_req), 32'd1);
      checkOutput("hold_addr", bus.inst_addr, EXC_ADDR);
      tick();
    end
    checkOutput("hold_addr_last", bus.inst_addr, EXC_ADDR);
    bus.inst_addr_ok = 1'b1;
    tick();
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b1;
    bus.inst_rdata   = EXC_ADDR;
    tick();
    bus.inst_data_ok = 1'b0;
    checkOutput("req_drop_valid", 32'(if_valid), 32'd0);
    checkOutput("req_drop_addr", bus.inst_addr, 32'h1234_5678);

    // reset in WAIT, stale data_ok arrives during IDLE
    bus.inst_addr_ok = 1'b1;
    tick();
    bus.inst_addr_ok = 1'b0;
    resetn = 1'b0;
    tick();
    checkResetState("wait_reset");
    resetn = 1'b1;
    bus.inst_data_ok = 1'b1;
    bus.inst_rdata   = 32'h1234_5678;
    tick();
    bus.inst_data_ok = 1'b0;
    checkOutput("stale_valid", 32'(if_valid), 32'd0);
    checkOutput("stale_addr", bus.inst_addr, RESET_ADDR);

    // PC increment wraps at the top of the address space
    fetchZeroWait(RESET_ADDR);
    applyStimulus(1'b0, 1'b1, 32'hffff_fffc, 1'b0, 1'b0, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    fetchZeroWait(32'hffff_fffc);
    tick();
    checkOutput("wrap_addr", bus.inst_addr, 32'd0);

    // Randomized run: the model tracks which PC decode should see next, and treats a
    // fetch as dirty if any redirect occurred since its request was first raised.
    first = 1'b1;
    prev_req = 1'b0; prev_aok = 1'b0; prev_addr = '0; prev_rstn = 1'b1;
    exp_pc = RESET_ADDR; out_addr = '0;
    model_valid = 1'b0; dirty = 1'b0; outstanding = 1'b0; stale_pending = 1'b0;
    lat = 0; since_deliv = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if (!first) begin
        checkOutput("rnd_valid", 32'(if_valid), 32'(model_valid));
        if (model_valid) begin
          checkOutput("rnd_pc", if_pc, exp_pc);
          checkOutput("rnd_inst", if_inst, memWord(exp_pc));
        end
        if (!prev_rstn) begin
          checkResetState("rnd_reset");
        end else begin
          if (outstanding) begin
            checkOutput("rnd_req_busy", 32'(bus.inst_req), 32'd0);
          end
          if (prev_req && !prev_aok) begin
            checkOutput("rnd_req_held", 32'(bus.inst_req), 32'd1);
            checkOutput("rnd_addr_held", bus.inst_addr, prev_addr);
          end
        end
        if (bus.inst_req && !prev_req) begin
          checkOutput("rnd_req_addr", bus.inst_addr, exp_pc);
          dirty = 1'b0;
        end
      end
      since_deliv = model_valid ? 0 : since_deliv + 1;
      if (since_deliv > 400) begin
        checkOutput("rnd_liveness", 32'(since_deliv), 32'd0);
        since_deliv = 0;
      end

      resetn = first ? 1'b0 : (!prev_rstn ? 1'b1 : ($urandom_range(0, 199) != 0));
      applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 23) == 0, randTarget(),
                    $urandom_range(0, 23) == 0, $urandom_range(0, 23) == 0, randTarget());
      bus.inst_addr_ok = ($urandom_range(0, 2) != 0);
      bus.inst_data_ok = 1'b0;
      bus.inst_rdata   = $urandom;
      if (stale_pending) begin
        bus.inst_data_ok = 1'b1;
        stale_pending    = 1'b0;
      end else if (outstanding) begin
        if (lat == 0) begin
          bus.inst_data_ok = 1'b1;
          bus.inst_rdata   = memWord(out_addr);
        end else begin
          lat--;
        end
      end

      redir   = eret | exc_oc | br_take;
      deliver = outstanding & bus.inst_data_ok;
      if (!resetn) begin
        stale_pending = (outstanding && !bus.inst_data_ok) || (bus.inst_req && bus.inst_addr_ok);
        outstanding   = 1'b0;
        model_valid   = 1'b0;
        dirty         = 1'b0;
        exp_pc        = RESET_ADDR;
      end else begin
        if (deliver) outstanding = 1'b0;
        if (bus.inst_req && bus.inst_addr_ok) begin
          outstanding = 1'b1;
          out_addr    = bus.inst_addr;
          lat         = $urandom_range(0, 3);
        end
        if (model_valid) begin
          if (redir || !stall) begin
            model_valid = 1'b0;
            if (!redir) exp_pc = exp_pc + 32'd4;
          end
        end else if (deliver && !dirty && !redir) begin
          model_valid = 1'b1;
        end
        if (redir) begin
          exp_pc = eret ? epc : (exc_oc ? EXC_ADDR : br_target);
          dirty  = 1'b1;
        end
      end
      prev_req  = bus.inst_req;
      prev_aok  = bus.inst_addr_ok;
      prev_addr = bus.inst_addr;
      prev_rstn = resetn;
      first     = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch_ctrl.md
# inst_fetch_ctrl

Instruction-fetch sequencer for the IF stage. It owns the fetch PC, merges the redirect sources (eret, exception, branch) with fixed priority, and drives the instruction-side SRAM-like bus (req / addr_ok / data_ok) with one transaction outstanding at a time. It buffers one fetched instruction toward decode, holds it under pipeline stall, and drops in-flight fetches that a redirect has made stale.

## Interface
- RESET_ADDR, 32'hbfc0_0000: first fetch address after reset.
- EXC_ADDR, 32'hbfc0_0380: exception entry address.
- clk  in  1  single clock; all state updates on posedge clk.
- resetn  in  1  synchronous, active-low reset.
- stall  in  1  decode cannot accept; an instruction is consumed in a cycle with if_valid=1 and stall=0.
- br_take  in  1  branch redirect request, valid for one cycle.
- br_target  in  32  branch target.
- exc_oc  in  1  exception redirect to EXC_ADDR.
- eret  in  1  eret redirect to epc.
- epc  in  32  eret return address.
- inst_req  out  1  bus request.
- inst_addr  out  32  request address; stable while inst_req=1 and addr_ok=0.
- inst_addr_ok  in  1  request accepted this cycle.
- inst_data_ok  in  1  read data returned this cycle.
- inst_rdata  in  32  read data.
- if_valid  out  1  if_pc/if_inst hold a valid instruction.
- if_pc  out  32  PC of the buffered instruction.
- if_inst  out  32  buffered instruction word.

## Operation
- Redirect this cycle: redir = eret | exc_oc | br_take. Target priority: eret→epc, else exc_oc→EXC_ADDR, else br_target.
- Registers: state, fetch_pc (drives inst_addr), cancel flag, pend_pc, if_valid/if_pc/if_inst. inst_req = (state==REQ).
- IDLE (reset state): next cycle → REQ. fetch_pc = redirect target if redir, else RESET_ADDR. A data_ok seen in IDLE is ignored.
- REQ, no addr_ok: hold inst_req and inst_addr unchanged. If redir, set cancel=1 and pend_pc=target. fetch_pc does not change while the request is pending.
- REQ, addr_ok=1: → WAIT. A redir in the same cycle sets cancel=1 and pend_pc=target.
- WAIT, no data_ok: if redir, set cancel=1 and pend_pc=target. A later redirect overwrites pend_pc.
- WAIT, data_ok=1 and redir=1: discard the data. → REQ with fetch_pc = current target. Clear cancel.
- WAIT, data_ok=1, cancel=1, no redir: discard the data. → REQ with fetch_pc=pend_pc. Clear cancel.
- WAIT, data_ok=1, cancel=0, no redir: capture if_inst=inst_rdata and if_pc=fetch_pc, set if_valid=1. → HOLD.
- HOLD, redir: clear if_valid. fetch_pc=target. → REQ.
- HOLD, stall=1, no redir: hold everything.
- HOLD, stall=0, no redir: instruction consumed. Clear if_valid, fetch_pc=fetch_pc+4 (mod 2^32, wraps 0xffff_fffc→0). → REQ.
- At most one bus transaction is outstanding. inst_req is never asserted in WAIT or HOLD.
- A discarded instruction never reaches if_valid=1.

## Timing
- Reset (resetn=0 at an edge): state=IDLE, inst_req=0, inst_addr=RESET_ADDR, if_valid=0, if_pc=0, if_inst=0, cancel=0, pend_pc=0. Applies from any state; an outstanding transaction is abandoned.
- First inst_req=1 with inst_addr=RESET_ADDR appears in the 2nd cycle after resetn rises (cycle 1 is IDLE).
- With a zero-wait bus (addr_ok in the REQ cycle, data_ok the next cycle) and stall=0, the sequence is REQ, WAIT, HOLD: 1 instruction per 3 cycles.
- if_valid rises the cycle after the accepted data_ok. It falls the cycle after consumption or redirect.
- Redirect to first request of the new target: from HOLD, 1 cycle. From WAIT, the cycle after data_ok returns.

## Test plan
- Reset, then zero-wait bus returning the address as data, stall=0 → inst_addr sequence bfc00000, bfc00004, bfc00008; if_pc/if_inst match each address; if_valid pulses once per 3 cycles.
- Instruction bfc00000 in HOLD, stall=1 for 5 cycles → if_valid, if_pc and if_inst stable, inst_req=0 throughout; after stall drops, next inst_addr=bfc00004.
- br_take=1, br_target=bfc00100 while in WAIT for bfc00004; data_ok 3 cycles later → no if_valid for bfc00004; next inst_addr=bfc00100.
- eret=1 with epc=80001000, exc_oc=1 and br_take=1 in the same HOLD cycle → next request 80001000. Same cycle without eret → bfc00380.
- addr_ok held low 4 cycles while br_take fires in REQ → inst_addr held at the original address until addr_ok; its data is discarded; next request is the branch target.
- resetn=0 for one cycle while in WAIT, stale data_ok arrives during IDLE → ignored, if_valid=0; first request is RESET_ADDR.
